// File: rtl/apb_spi_pkg.sv
// Shared constants for the APB SPI register interface: register map,
// write masks, reset values, bit positions and state encodings.
package apb_spi_pkg;

   // Register map (3-bit APB address space, 6 and 7 unmapped)
   localparam logic [2:0] ADDR_CR1 = 3'd0;
   localparam logic [2:0] ADDR_CR2 = 3'd1;
   localparam logic [2:0] ADDR_BR  = 3'd2;
   localparam logic [2:0] ADDR_SR  = 3'd3;
   localparam logic [2:0] ADDR_FCR = 3'd4;
   localparam logic [2:0] ADDR_DR  = 3'd5;

   // Reset values and write masks
   localparam logic [7:0] CR1_RESET = 8'h04;
   localparam logic [7:0] CR2_RESET = 8'h00;
   localparam logic [7:0] BR_RESET  = 8'h00;
   localparam logic [7:0] CR2_MASK  = 8'h1B;
   localparam logic [7:0] BR_MASK   = 8'h77;

   // FIFO level width: holds 0..8 for the largest legal depth
   localparam int LEVEL_W = 4;

   // CR1 bit positions
   localparam int CR1_SPIE  = 7;
   localparam int CR1_SPE   = 6;
   localparam int CR1_SPTIE = 5;
   localparam int CR1_MSTR  = 4;
   localparam int CR1_CPOL  = 3;
   localparam int CR1_CPHA  = 2;
   localparam int CR1_SSOE  = 1;
   localparam int CR1_LSBFE = 0;

   // CR2 bit positions
   localparam int CR2_MODFEN  = 4;
   localparam int CR2_SPISWAI = 1;

   // SR bit positions
   localparam int SR_SPIF   = 7;
   localparam int SR_SPTEF  = 5;
   localparam int SR_MODF   = 4;
   localparam int SR_TXFULL = 3;
   localparam int SR_RXOVF  = 2;

   // FCR command bits
   localparam int FCR_FLUSH_TX = 0;
   localparam int FCR_FLUSH_RX = 1;
   localparam int FCR_CLR_OVF  = 2;

   typedef enum logic [1:0] {
      MODE_RUN  = 2'b00,
      MODE_WAIT = 2'b01,
      MODE_STOP = 2'b10
   } spi_mode_e;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'b00,
      APB_SETUP  = 2'b01,
      APB_ACCESS = 2'b10
   } apb_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with push/pop/flush. A pop on empty is ignored, a push
// on full is accepted only when a pop happens in the same cycle, and flush
// overrides both.
module spi_sync_fifo
   import apb_spi_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LEVEL_W'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage write; contents need no reset since level gates visibility
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
      end
   end

endmodule

// File: rtl/apb_spi_fifo_regif.sv
// APB register interface of an SPI controller with TX/RX FIFOs.
// Handshake: tx_data is offered while tx_valid=1 and leaves the FIFO on a
// cycle with tx_valid&tx_ready; rx_data is taken on every rx_valid cycle
// (no backpressure) unless the block is in stop mode.
module apb_spi_fifo_regif
   import apb_spi_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic [2:0]        PADDR,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              ss,
   input  logic              tip,
   output logic              mstr,
   output logic              cpol,
   output logic              cpha,
   output logic              lsbfe,
   output logic              spe,
   output logic              spiswai,
   output logic [2:0]        sppr,
   output logic [2:0]        spr,
   output logic [1:0]        spi_mode,
   output logic              spi_interrupt_request
);

   apb_state_e         apb_state;
   spi_mode_e          mode;
   logic [7:0]         cr1, cr2, br;
   logic               rxovf;
   logic               tx_full, tx_empty, rx_full, rx_empty;
   logic [LEVEL_W-1:0] tx_level, rx_level;
   logic [DATA_W-1:0]  rx_head;
   logic               access, err, wr_ok, rd_ok, fcr_wr;
   logic               tx_push, tx_pop, rx_push, rx_pop;
   logic               flush_tx, flush_rx, clr_ovf, ovf_set;
   logic               spif, sptef, modf;
   logic [7:0]         sr;
   logic [DATA_W-1:0]  rdata;

   // The access phase is the enable cycle that follows a recognised setup
   assign access = (apb_state == APB_SETUP) && PSEL && PENABLE;
   assign PREADY = access;

   // APB phase tracker; reset mid-transfer drops back to IDLE
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) apb_state <= APB_IDLE;
      else begin
         case (apb_state)
            APB_IDLE:   apb_state <= (PSEL && !PENABLE) ? APB_SETUP : APB_IDLE;
            APB_SETUP:  apb_state <= (PSEL && PENABLE) ? APB_ACCESS :
                                     (PSEL ? APB_SETUP : APB_IDLE);
            APB_ACCESS: apb_state <= PSEL ? APB_SETUP : APB_IDLE;
            default:    apb_state <= APB_IDLE;
         endcase
      end
   end

   // Slave error decode for the current access
   always_comb begin
      err = 1'b0;
      if (access) begin
         case (PADDR)
            ADDR_CR1, ADDR_CR2, ADDR_BR: err = PWRITE && tip;
            ADDR_SR:                     err = PWRITE;
            ADDR_FCR:                    err = 1'b0;
            ADDR_DR:                     err = PWRITE ? tx_full : rx_empty;
            default:                     err = 1'b1;
         endcase
      end
   end
   assign PSLVERR = err;

   assign wr_ok    = access && PWRITE && !err;
   assign rd_ok    = access && !PWRITE && !err;
   assign fcr_wr   = wr_ok && (PADDR == ADDR_FCR);
   assign flush_tx = fcr_wr && PWDATA[FCR_FLUSH_TX];
   assign flush_rx = fcr_wr && PWDATA[FCR_FLUSH_RX];
   assign clr_ovf  = fcr_wr && PWDATA[FCR_CLR_OVF];
   assign tx_push  = wr_ok && (PADDR == ADDR_DR);
   assign tx_valid = !tx_empty && (mode != MODE_STOP);
   assign tx_pop   = tx_valid && tx_ready;
   assign rx_push  = rx_valid && (mode != MODE_STOP);
   assign rx_pop   = rd_ok && (PADDR == ADDR_DR);
   // A word is lost only if the RX FIFO stays full through this cycle
   assign ovf_set  = rx_push && rx_full && !rx_pop && !flush_rx;

   spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .pop(tx_pop), .flush(flush_tx),
      .wdata(PWDATA), .rdata(tx_data), .full(tx_full), .empty(tx_empty), .level(tx_level)
   );

   spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .pop(rx_pop), .flush(flush_rx),
      .wdata(rx_data), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
   );

   // Control registers and the sticky overflow flag (clear beats set)
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cr1   <= CR1_RESET;
         cr2   <= CR2_RESET;
         br    <= BR_RESET;
         rxovf <= 1'b0;
      end else begin
         if (wr_ok) begin
            case (PADDR)
               ADDR_CR1: cr1 <= PWDATA[7:0];
               ADDR_CR2: cr2 <= PWDATA[7:0] & CR2_MASK;
               ADDR_BR:  br  <= PWDATA[7:0] & BR_MASK;
               default:  ;
            endcase
         end
         if (clr_ovf)      rxovf <= 1'b0;
         else if (ovf_set) rxovf <= 1'b1;
      end
   end

   // Low-power mode sequencer; the unused encoding recovers to run
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) mode <= MODE_RUN;
      else begin
         case (mode)
            MODE_RUN:  if (!spe) mode <= MODE_WAIT;
            MODE_WAIT: if (spe) mode <= MODE_RUN;
                       else if (spiswai) mode <= MODE_STOP;
            MODE_STOP: if (spe) mode <= MODE_RUN;
                       else if (!spiswai) mode <= MODE_WAIT;
            default:   mode <= MODE_RUN;
         endcase
      end
   end

   assign spif  = !rx_empty;
   assign sptef = tx_empty;
   assign modf  = !ss && cr1[CR1_MSTR] && cr2[CR2_MODFEN] && !cr1[CR1_SSOE];
   assign sr    = {spif, 1'b0, sptef, modf, tx_full, rxovf, 2'b00};

   // Read data mux; zero outside a successful read access
   always_comb begin
      rdata = '0;
      if (rd_ok) begin
         case (PADDR)
            ADDR_CR1: rdata = DATA_W'(cr1);
            ADDR_CR2: rdata = DATA_W'(cr2);
            ADDR_BR:  rdata = DATA_W'(br);
            ADDR_SR:  rdata = DATA_W'(sr);
            ADDR_FCR: rdata = DATA_W'({rx_level, tx_level});
            ADDR_DR:  rdata = rx_head;
            default:  rdata = '0;
         endcase
      end
   end
   assign PRDATA = rdata;

   assign mstr     = cr1[CR1_MSTR];
   assign cpol     = cr1[CR1_CPOL];
   assign cpha     = cr1[CR1_CPHA];
   assign lsbfe    = cr1[CR1_LSBFE];
   assign spe      = cr1[CR1_SPE];
   assign spiswai  = cr2[CR2_SPISWAI];
   assign sppr     = br[6:4];
   assign spr      = br[2:0];
   assign spi_mode = mode;

   assign spi_interrupt_request = (cr1[CR1_SPIE] && (spif || modf || rxovf)) ||
                                  (cr1[CR1_SPTIE] && sptef);

endmodule

// File: tb/tb_apb_spi_fifo_regif.sv
// Bench for apb_spi_fifo_regif: directed scenarios plus a randomized phase,
// all checked against a queue-based register/FIFO model.
module tb_apb_spi_fifo_regif;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic [2:0]    PADDR;
   logic          PSEL, PENABLE, PWRITE;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY, PSLVERR;
   logic [DW-1:0] tx_data;
   logic          tx_valid, tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid, ss, tip;
   logic          mstr, cpol, cpha, lsbfe, spe, spiswai;
   logic [2:0]    sppr, spr;
   logic [1:0]    spi_mode;
   logic          spi_interrupt_request;

   // clock / reset block
   always #5 PCLK = ~PCLK;

   apb_spi_fifo_regif #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .ss(ss), .tip(tip),
      .mstr(mstr), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .spe(spe), .spiswai(spiswai),
      .sppr(sppr), .spr(spr), .spi_mode(spi_mode), .spi_interrupt_request(spi_interrupt_request)
   );

   int n_checks = 0;
   int n_bad    = 0;

   // scoreboard: {pslverr, prdata} per APB access, in issue order
   logic [DW:0]   exp_q[$];
   logic [DW:0]   mon_e;

   // reference model state
   logic [DW-1:0] m_tx[$];
   logic [DW-1:0] m_rx[$];
   logic [7:0]    m_cr1, m_cr2, m_br;
   logic          m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_tx.delete();
      m_rx.delete();
      m_cr1 = 8'h04;
      m_cr2 = 8'h00;
      m_br  = 8'h00;
      m_ovf = 1'b0;
   endtask

   function automatic logic m_modf();
      return !ss && m_cr1[4] && m_cr2[4] && !m_cr1[1];
   endfunction

   function automatic logic [7:0] m_sr();
      return {m_rx.size() != 0, 1'b0, m_tx.size() == 0, m_modf(),
              m_tx.size() == DEPTH, m_ovf, 2'b00};
   endfunction

   function automatic logic m_irq();
      return (m_cr1[7] && (m_rx.size() != 0 || m_modf() || m_ovf)) ||
             (m_cr1[5] && m_tx.size() == 0);
   endfunction

   // driver: one APB transfer, optionally with an rx word in the access cycle
   task automatic apb(input logic wr, input logic [2:0] addr, input logic [DW-1:0] wdata,
                      input logic push_rx = 1'b0, input logic [DW-1:0] rx_word = '0);
      logic          err;
      logic [DW-1:0] rd;
      logic          rx_flushed;
      err = 1'b0;
      rd  = '0;
      rx_flushed = 1'b0;
      case (addr)
         3'd0: if (wr) begin if (tip) err = 1'b1; else m_cr1 = wdata[7:0]; end
               else rd = DW'(m_cr1);
         3'd1: if (wr) begin if (tip) err = 1'b1; else m_cr2 = wdata[7:0] & 8'h1B; end
               else rd = DW'(m_cr2);
         3'd2: if (wr) begin if (tip) err = 1'b1; else m_br = wdata[7:0] & 8'h77; end
               else rd = DW'(m_br);
         3'd3: if (wr) err = 1'b1; else rd = DW'(m_sr());
         3'd4: if (wr) begin
                  if (wdata[0]) m_tx.delete();
                  if (wdata[1]) begin m_rx.delete(); rx_flushed = 1'b1; end
               end else rd = DW'(m_rx.size() * 16 + m_tx.size());
         3'd5: if (wr) begin
                  if (m_tx.size() == DEPTH) err = 1'b1; else m_tx.push_back(wdata);
               end else begin
                  if (m_rx.size() == 0) err = 1'b1; else rd = m_rx.pop_front();
               end
         default: err = 1'b1;
      endcase
      if (push_rx && !rx_flushed) begin
         if (m_rx.size() < DEPTH) m_rx.push_back(rx_word);
         else m_ovf = 1'b1;
      end
      if (wr && addr == 3'd4 && wdata[2]) m_ovf = 1'b0;
      exp_q.push_back({err, rd});

      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; rx_valid = push_rx; rx_data = rx_word;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
      check("apb_response_seen", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic rx_push(input logic [DW-1:0] w);
      if (m_rx.size() < DEPTH) m_rx.push_back(w);
      else m_ovf = 1'b1;
      @(posedge PCLK); #1;
      rx_valid = 1'b1; rx_data = w;
      @(posedge PCLK); #1;
      rx_valid = 1'b0;
   endtask

   task automatic check_irq();
      @(negedge PCLK);
      check("irq", spi_interrupt_request, m_irq());
   endtask

   // monitor: APB responses and TX handshakes, sampled on the falling edge
   always @(negedge PCLK) begin
      if (PREADY) begin
         if (exp_q.size() == 0) check("apb_unexpected_pready", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            check("apb_prdata", PRDATA, mon_e[DW-1:0]);
            check("apb_pslverr", PSLVERR, mon_e[DW]);
         end
      end
      if (tx_valid && tx_ready) begin
         if (m_tx.size() == 0) check("tx_unexpected", 1, 0);
         else check("tx_data", tx_data, m_tx.pop_front());
      end
   end

   initial begin
      logic [DW-1:0] w;
      PRESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 3'd0;
      PWDATA = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; ss = 1'b1; tip = 1'b0;
      model_reset();

      // outputs held quiet during reset even with a bus request present
      repeat (2) @(negedge PCLK);
      check("rst_pready", PREADY, 0);
      check("rst_pslverr", PSLVERR, 0);
      check("rst_prdata", PRDATA, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_spi_mode", spi_mode, 0);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;

      // reset register values
      apb(1'b0, 3'd0, '0);
      apb(1'b0, 3'd3, '0);
      apb(1'b0, 3'd4, '0);
      apb(1'b0, 3'd1, '0);
      apb(1'b0, 3'd2, '0);
      check_irq();

      // reset arriving during a write transfer discards it
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd0; PWDATA = 8'hFF;
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      #2 PRESETn = 1'b1; PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      model_reset();
      apb(1'b0, 3'd0, '0);

      // fill TX, then one write too many
      for (int i = 0; i < 4; i++) apb(1'b1, 3'd5, DW'(8'hA1 + i));
      apb(1'b0, 3'd4, '0);
      apb(1'b0, 3'd3, '0);
      apb(1'b1, 3'd5, 8'h5A);
      apb(1'b0, 3'd4, '0);

      // drain TX at one word per cycle
      @(posedge PCLK); #1;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         check("tx_valid_drain", tx_valid, 1);
      end
      @(negedge PCLK);
      check("tx_valid_after_drain", tx_valid, 0);
      check("tx_model_drained", m_tx.size(), 0);
      @(posedge PCLK); #1;
      tx_ready = 1'b0;
      apb(1'b0, 3'd3, '0);

      // RX overflow, drain, read from empty
      for (int i = 0; i < 5; i++) rx_push(DW'(8'h11 + i));
      apb(1'b0, 3'd3, '0);
      check_irq();
      for (int i = 0; i < 5; i++) apb(1'b0, 3'd5, '0);
      apb(1'b1, 3'd4, 8'h04);
      apb(1'b0, 3'd3, '0);

      // low-power sequencing
      apb(1'b1, 3'd0, 8'h44);
      repeat (2) @(negedge PCLK);
      check("mode_run", spi_mode, 2'b00);
      apb(1'b1, 3'd1, 8'h02);
      apb(1'b1, 3'd0, 8'h04);
      @(negedge PCLK); check("mode_seq_run", spi_mode, 2'b00);
      @(negedge PCLK); check("mode_seq_wait", spi_mode, 2'b01);
      @(negedge PCLK); check("mode_seq_stop", spi_mode, 2'b10);
      apb(1'b1, 3'd5, 8'h3C);
      @(negedge PCLK); check("tx_valid_in_stop", tx_valid, 0);
      apb(1'b1, 3'd0, 8'h44);
      repeat (2) @(negedge PCLK);
      check("mode_back_run", spi_mode, 2'b00);
      check("tx_valid_in_run", tx_valid, 1);
      apb(1'b1, 3'd1, 8'h00);
      apb(1'b1, 3'd4, 8'h01);

      // full flush with a same-cycle rx push
      apb(1'b1, 3'd5, 8'h77);
      for (int i = 0; i < 5; i++) rx_push(DW'(8'h60 + i));
      apb(1'b1, 3'd4, 8'h07, 1'b1, 8'hEE);
      apb(1'b0, 3'd4, '0);
      apb(1'b0, 3'd3, '0);

      // full RX with simultaneous pop and push keeps the level, no overflow
      for (int i = 0; i < 4; i++) rx_push(DW'(8'h30 + i));
      apb(1'b0, 3'd5, '0, 1'b1, 8'h34);
      apb(1'b0, 3'd3, '0);
      apb(1'b0, 3'd4, '0);
      apb(1'b1, 3'd4, 8'h03);
      // empty RX with read plus push: push only, read errors
      apb(1'b0, 3'd5, '0, 1'b1, 8'h99);
      apb(1'b0, 3'd4, '0);

      // randomized mix; spiswai kept low so stop mode is never entered
      for (int i = 0; i < 250; i++) begin
         int op;
         op  = $urandom_range(0, 9);
         ss  = 1'($urandom_range(0, 1));
         tip = ($urandom_range(0, 3) == 0);
         w   = DW'($urandom);
         case (op)
            0, 1: apb(1'b1, 3'd5, w, ($urandom_range(0, 3) == 0), DW'($urandom));
            2, 3: apb(1'b0, 3'd5, '0, ($urandom_range(0, 2) == 0), DW'($urandom));
            4:    apb(1'b0, 3'($urandom_range(0, 4)), '0, ($urandom_range(0, 3) == 0), DW'($urandom));
            5: begin
               int a;
               a = $urandom_range(0, 2);
               if (a == 1) w[1] = 1'b0;
               apb(1'b1, 3'(a), w);
            end
            6:    apb(1'b1, 3'd4, DW'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1), DW'($urandom));
            7:    apb(1'($urandom_range(0, 1)), 3'($urandom_range(6, 7)), w);
            8:    apb(1'b1, 3'd3, w);
            default: rx_push(w);
         endcase
         check_irq();
      end

      repeat (3) @(negedge PCLK);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
